// File: rtl/tppe_lif_neuron_if.sv
// rtl/tppe_lif_neuron_if.sv - psum-in / spike-out handshake bundle for the LIF neuron
interface tppe_lif_neuron_if #(
    parameter int T = 4,
    parameter int Q = 4,
    parameter int V = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [Q-1:0] in_psum [T-1:0];
    logic [V-1:0] threshold;
    logic [V-1:0] leak;
    logic         out_valid;
    logic         out_ready;
    logic [T-1:0] out_spikes;
    logic [V-1:0] out_vmem;

    modport master (
        output in_valid, in_psum, threshold, leak, out_ready,
        input  in_ready, out_valid, out_spikes, out_vmem
    );

    modport slave (
        input  in_valid, in_psum, threshold, leak, out_ready,
        output in_ready, out_valid, out_spikes, out_vmem
    );
endinterface

// File: rtl/tppe_lif_neuron.sv
// rtl/tppe_lif_neuron.sv - sequential leaky-integrate-and-fire neuron over a T-step psum vector
module tppe_lif_neuron #(
    parameter int T = 4,
    parameter int Q = 4,
    parameter int V = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    tppe_lif_neuron_if.slave bus
);
    localparam int SW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [Q-1:0]  psum_q [T];
    logic [V-1:0]  thr_q;
    logic [V-1:0]  leak_q;
    logic [V-1:0]  mem_q;
    logic [T-1:0]  spk_q;
    logic [T-1:0]  spikes_q;
    logic [V-1:0]  vmem_q;
    logic [SW-1:0] step_q;

    logic          accept;
    logic          last_step;
    logic [V:0]    sum;
    logic [V-1:0]  sat;
    logic [V-1:0]  leaked;
    logic          fire;
    logic [V-1:0]  mem_nxt;
    logic [T-1:0]  spk_nxt;

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_step = (step_q == SW'(T - 1));

    // One timestep: saturating integrate, floored leak, subtractive reset on fire.
    always_comb begin
        sum     = {1'b0, mem_q} + {{(V + 1 - Q){1'b0}}, psum_q[step_q]};
        sat     = sum[V] ? {V{1'b1}} : sum[V-1:0];
        leaked  = (sat > leak_q) ? (sat - leak_q) : '0;
        fire    = (leaked >= thr_q);
        mem_nxt = fire ? (leaked - thr_q) : leaked;
        spk_nxt = spk_q;
        spk_nxt[step_q] = spk_q[step_q] | fire;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = INTEG;
            INTEG:   if (last_step) state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state == IDLE);
        bus.out_valid  = (state == OUT);
        bus.out_spikes = spikes_q;
        bus.out_vmem   = vmem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < T; i++) psum_q[i] <= '0;
            thr_q    <= '0;
            leak_q   <= '0;
            mem_q    <= '0;
            spk_q    <= '0;
            step_q   <= '0;
            spikes_q <= '0;
            vmem_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < T; i++) psum_q[i] <= bus.in_psum[i];
                        thr_q  <= bus.threshold;
                        leak_q <= bus.leak;
                        mem_q  <= '0;
                        spk_q  <= '0;
                        step_q <= '0;
                    end
                end
                INTEG: begin
                    mem_q  <= mem_nxt;
                    spk_q  <= spk_nxt;
                    step_q <= step_q + SW'(1);
                    if (last_step) begin
                        spikes_q <= spk_nxt;
                        vmem_q   <= mem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
